// File: rtl/nibble_bus_arbiter.sv
// nibble_bus_arbiter
//
// Round-robin arbiter for a shared 4-bit tri-state bus with four sources.
// One source at a time gets its buffer enable; each ownership is limited to
// MAX_HOLD cycles, and a configurable number of all-disabled turnaround
// cycles separates owners so two buffers never fight on the bus.
//
// Request protocol: req[i] is a level request.  A source raises it and keeps
// it high for as long as it wants the bus.  Dropping it while owning the bus
// releases the bus on the next edge.  There is no separate acknowledge; the
// source watches en[i] (or owner/busy) to know when it may drive.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per ownership (1..15)
//   TURN_CYC  all-disabled turnaround cycles after a release (0..3)
//
// Ports:
//   clock      rising-edge system clock
//   reset      synchronous reset, active low
//   req[3:0]   per-source bus request (level)
//   en[3:0]    per-source tri-state enable, one-hot or zero (registered)
//   owner[1:0] current or most recent grantee (registered)
//   busy       high while any en bit is high (registered)
//   timeout    one-cycle pulse in the cycle after a forced release
//   dbg_state  FSM state for observation: 0=IDLE, 1=GRANT, 2=TURN

module nibble_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] en,
    output logic [1:0] owner,
    output logic       busy,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_HOLD_L = 4'(MAX_HOLD);
    localparam logic [1:0] TURN_CYC_L = 2'(TURN_CYC);

    state_t     state;
    logic [1:0] ptr;        // first index searched at the next arbitration
    logic [3:0] hold;       // grant cycles used by the current owner
    logic [1:0] turn_cnt;   // turnaround cycles spent so far

    logic       win_valid;
    logic [1:0] win;

    // Round-robin search.  Walking the offsets from highest to lowest lets
    // the lowest offset from ptr (the highest priority) overwrite the rest.
    always_comb begin
        logic [1:0] idx;
        win_valid = 1'b0;
        win       = ptr;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win_valid = 1'b1;
                win       = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            en       <= 4'b0000;
            owner    <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= 2'd0;
            hold     <= 4'd0;
            turn_cnt <= 2'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state <= GRANT;
                        en    <= 4'b0001 << win;
                        owner <= win;
                        busy  <= 1'b1;
                        hold  <= 4'd1;
                    end
                end

                GRANT: begin
                    // Voluntary release wins over forced release: a source
                    // that drops req on its last allowed cycle gets no timeout.
                    if (!req[owner] || (hold == MAX_HOLD_L)) begin
                        en      <= 4'b0000;
                        busy    <= 1'b0;
                        hold    <= 4'd0;
                        ptr     <= owner + 2'd1;
                        timeout <= req[owner];
                        if (TURN_CYC > 0) begin
                            state    <= TURN;
                            turn_cnt <= 2'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        hold <= hold + 4'd1;
                    end
                end

                TURN: begin
                    // Requests are not looked at here; IDLE adds one more
                    // all-zero cycle before the next grant can appear.
                    if (turn_cnt == TURN_CYC_L) begin
                        state    <= IDLE;
                        turn_cnt <= 2'd0;
                    end else begin
                        turn_cnt <= turn_cnt + 2'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    en    <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/nibble_bus_arbiter.md
NIBBLE_BUS_ARBITER -- requirements
Module: nibble_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-low.
REQ-002 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles per ownership, legal range 1..15.
REQ-003 Parameter TURN_CYC, default 1, SHALL set the number of all-disabled bus-turnaround cycles between owners, legal range 0..3.
REQ-004 Port clock, input, 1 bit: rising-edge system clock.
REQ-005 Port reset, input, 1 bit: synchronous reset, asserted when 0.
REQ-006 Port req, input, 4 bits: req[i]=1 means source i wants to drive the shared 4-bit bus; it stays high while ownership is wanted.
REQ-007 Port en, output, 4 bits: en[i] drives the enable of source i's tri-state bus buffer.
REQ-008 Port owner, output, 2 bits: index of the current or most recent grantee.
REQ-009 Port busy, output, 1 bit: high while any en bit is high.
REQ-010 Port timeout, output, 1 bit: one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-011 All outputs SHALL be registered; en SHALL be one-hot or all-zero in every cycle.
REQ-012 The FSM SHALL have three states: IDLE, GRANT and TURN.
REQ-013 IDLE: en=0, busy=0; if any req bit is sampled high, the block SHALL select a winner and enter GRANT on the next edge.
REQ-014 Winner selection SHALL be round-robin: the search starts at index ptr and proceeds ptr, ptr+1, ... mod 4; the first index with req high wins.
REQ-015 Grant latency SHALL be one cycle: req sampled high at edge N gives en[winner]=1 and owner=winner after edge N.
REQ-016 GRANT: en[owner]=1, busy=1, and the 4-bit hold counter SHALL increment every cycle starting from 1 in the first grant cycle.
REQ-017 Voluntary release: when req[owner]=0 is sampled in GRANT, en SHALL be 0 after that edge.
REQ-018 Forced release: when the hold counter equals MAX_HOLD and req[owner] is still 1, en SHALL be 0 after that edge and timeout=1 for exactly that one cycle.
REQ-019 On any release, ptr SHALL become (owner+1) mod 4 and the hold counter SHALL clear.
REQ-020 On release with TURN_CYC>0, the next state SHALL be TURN; with TURN_CYC=0 it SHALL be IDLE.
REQ-021 TURN: en=0 for exactly TURN_CYC cycles, then the FSM SHALL enter IDLE; requests SHALL be ignored during TURN.
REQ-022 Between deassertion of one en bit and assertion of any en bit, at least TURN_CYC+1 all-zero cycles SHALL elapse (IDLE arbitration included).
REQ-023 A force-released requester that is the only requester SHALL regain the bus after the turnaround, with its hold count restarted at 1.
REQ-024 Changes on req bits other than req[owner] during GRANT SHALL NOT affect en.
REQ-025 owner SHALL hold its value through TURN and IDLE until the next grant.

Reset
REQ-026 When reset=0 at an edge: state=IDLE, en=0000, owner=00, busy=0, timeout=0, ptr=0, and the hold counter=0 after that edge, regardless of the current state, including in the middle of a grant.
REQ-027 While reset=0, req SHALL be ignored; the first grant may occur one edge after reset returns to 1.

Verification
REQ-028 Scenario: after reset, req=0100 for 3 cycles then 0000 -> en=0100 appears 1 cycle after req and lasts 3 cycles; en=0000 then follows; owner=2; timeout never asserts.
REQ-029 Scenario: req=1111 held, defaults -> grants follow the order 0,1,2,3,0, each lasting 8 cycles with timeout pulsed at the end; there is 1 en=0000 TURN cycle plus 1 IDLE cycle between grants.
REQ-030 Scenario: MAX_HOLD=4, req=0001 held -> en=0001 for 4 cycles, timeout pulse, 2 zero cycles, then en=0001 again.
REQ-031 Scenario: owner 1 granted, req=1011 simultaneously, then req[1] drops -> the next winner is 3 (ptr=2, req[2]=0), not 0.
REQ-032 Scenario: reset=0 asserted during the 3rd grant cycle -> en=0000, owner=0 and busy=0 on the next edge; with req=0010 still high and reset released, en=0010 appears 1 cycle later.
REQ-033 Scenario: TURN_CYC=0 with random req over 10000 cycles -> en stays one-hot or zero, and at least one zero cycle separates any two grants.
